// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives instruction-memory requests, fills the
// IF/ID register, parks one early-returning word in a skid buffer while
// decode stalls, and handles decode redirects (including in-flight drops).
// Optional macro FETCH_TIMEOUT_EN builds a request-timeout counter that raises
// a sticky Fetch_Err; without it Fetch_Err is tied low.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ID_PCSrc,
    input  logic [31:0] ID_new_PC,
    input  logic        Stall,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_RData,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC4,
    output logic        IF_Valid,
    output logic        Fetch_Err
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] target_q, target_d;
    logic        discard_q, discard_d;

    logic        consume_c;
    logic        if_free_c;
    logic [31:0] addr_inc_c;

    assign consume_c  = if_valid_q & ~Stall;
    assign if_free_c  = ~if_valid_q | consume_c;
    assign addr_inc_c = mem_addr_q + 32'd4;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the skid buffer is full exactly while in HOLD
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ: begin
                if (!ID_PCSrc && Mem_Ack && !discard_q && !if_free_c) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ID_PCSrc || !Stall) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Output decode: request is live only in REQ
    always_comb begin
        Mem_Req = 1'b0;
        if (state_q == ST_REQ) begin
            Mem_Req = 1'b1;
        end
    end

    // Datapath next values: fetch address, IF register, skid, redirect target
    always_comb begin
        mem_addr_d  = mem_addr_q;
        if_instr_d  = if_instr_q;
        if_pc4_d    = if_pc4_q;
        if_valid_d  = if_valid_q;
        skid_data_d = skid_data_q;
        skid_pc4_d  = skid_pc4_q;
        target_d    = target_q;
        discard_d   = discard_q;
        case (state_q)
            ST_BOOT: begin
                if (ID_PCSrc) begin
                    mem_addr_d = ID_new_PC;
                end
            end
            ST_REQ: begin
                if (ID_PCSrc) begin
                    if_valid_d = 1'b0;
                    if (Mem_Ack) begin
                        mem_addr_d = ID_new_PC;
                        discard_d  = 1'b0;
                    end else begin
                        // request in flight: its data must be dropped later
                        target_d  = ID_new_PC;
                        discard_d = 1'b1;
                    end
                end else begin
                    if (consume_c) begin
                        if_valid_d = 1'b0;
                    end
                    if (Mem_Ack) begin
                        if (discard_q) begin
                            mem_addr_d = target_q;
                            discard_d  = 1'b0;
                        end else begin
                            mem_addr_d = addr_inc_c;
                            if (if_free_c) begin
                                if_instr_d = Mem_RData;
                                if_pc4_d   = addr_inc_c;
                                if_valid_d = 1'b1;
                            end else begin
                                skid_data_d = Mem_RData;
                                skid_pc4_d  = addr_inc_c;
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (ID_PCSrc) begin
                    if_valid_d = 1'b0;
                    mem_addr_d = ID_new_PC;
                end else if (!Stall) begin
                    if_instr_d = skid_data_q;
                    if_pc4_d   = skid_pc4_q;
                    if_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mem_addr_q  <= RESET_PC;
            if_instr_q  <= 32'd0;
            if_pc4_q    <= 32'd0;
            if_valid_q  <= 1'b0;
            skid_data_q <= 32'd0;
            skid_pc4_q  <= 32'd0;
            target_q    <= 32'd0;
            discard_q   <= 1'b0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            if_instr_q  <= if_instr_d;
            if_pc4_q    <= if_pc4_d;
            if_valid_q  <= if_valid_d;
            skid_data_q <= skid_data_d;
            skid_pc4_q  <= skid_pc4_d;
            target_q    <= target_d;
            discard_q   <= discard_d;
        end
    end

    assign Mem_Addr       = mem_addr_q;
    assign IF_Instruction = if_instr_q;
    assign IF_PC4         = if_pc4_q;
    assign IF_Valid       = if_valid_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             fetch_err_q, fetch_err_d;

    // Count consecutive unanswered REQ cycles; error is sticky until reset
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        fetch_err_d = fetch_err_q;
        if (state_q == ST_REQ) begin
            if (Mem_Ack) begin
                tmo_cnt_d = '0;
            end else begin
                if (tmo_cnt_q != CNT_MAX) begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
                if (tmo_cnt_d == CNT_MAX) begin
                    fetch_err_d = 1'b1;
                end
            end
        end
    end

    // Timeout registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tmo_cnt_q   <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign Fetch_Err = fetch_err_q;
`else
    logic unused_timeout_c;
    assign unused_timeout_c = (TIMEOUT_CYCLES != 0);
    assign Fetch_Err        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, reset/timeout sequences,
// and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TMO    = 4;
    localparam bit          TMO_EN = 1'b1;
`else
    localparam int unsigned TMO    = 255;
    localparam bit          TMO_EN = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic        ID_PCSrc;
    logic [31:0] ID_new_PC;
    logic        Stall;
    logic        Mem_Ack;
    logic [31:0] Mem_RData;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC4;
    logic        IF_Valid;
    logic        Fetch_Err;

    fetch_sequencer #(
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ID_PCSrc       (ID_PCSrc),
        .ID_new_PC      (ID_new_PC),
        .Stall          (Stall),
        .Mem_Ack        (Mem_Ack),
        .Mem_RData      (Mem_RData),
        .Mem_Req        (Mem_Req),
        .Mem_Addr       (Mem_Addr),
        .IF_Instruction (IF_Instruction),
        .IF_PC4         (IF_PC4),
        .IF_Valid       (IF_Valid),
        .Fetch_Err      (Fetch_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        ID_PCSrc  = 1'b0;
        ID_new_PC = 32'd0;
        Stall     = 1'b0;
        Mem_Ack   = 1'b0;
        Mem_RData = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b0;
        cyc();
        cyc();
        Reset = 1'b1;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [31:0] p;
    } skid_t;

    bit          m_boot;
    bit          m_valid;
    logic [31:0] m_instr, m_pc4, m_addr, m_target;
    bit          m_discard;
    bit          m_err;
    int          m_wait;
    skid_t       m_skid[$];

    function automatic void m_reset();
        m_boot = 1'b1; m_valid = 1'b0; m_instr = 32'd0; m_pc4 = 32'd0;
        m_addr = RST_PC; m_target = 32'd0; m_discard = 1'b0; m_err = 1'b0;
        m_wait = 0; m_skid.delete();
    endfunction

    // Memory is asked for a word only when booted and nothing is parked
    function automatic bit m_req();
        return !m_boot && (m_skid.size() == 0);
    endfunction

    function automatic void m_step(input bit pcsrc, input logic [31:0] npc, input bit stall,
                                   input bit ack, input logic [31:0] rdata);
        bit was_req = m_req();
        bit fire    = was_req && ack;
        bit take    = m_valid && !stall;
        if (was_req && !ack) m_wait++;
        else if (fire) m_wait = 0;
        if (TMO_EN && was_req && !ack && m_wait >= int'(TMO)) m_err = 1'b1;
        if (m_boot) begin
            m_boot = 1'b0;
            return;
        end
        if (pcsrc) begin
            m_valid = 1'b0;
            m_skid.delete();
            if (was_req && !fire) begin
                m_target  = npc;
                m_discard = 1'b1;
            end else begin
                m_addr    = npc;
                m_discard = 1'b0;
            end
        end else if (m_skid.size() != 0) begin
            if (!stall) begin
                skid_t s = m_skid.pop_front();
                m_instr = s.d;
                m_pc4   = s.p;
                m_valid = 1'b1;
            end
        end else begin
            if (take) m_valid = 1'b0;
            if (fire) begin
                if (m_discard) begin
                    m_addr    = m_target;
                    m_discard = 1'b0;
                end else begin
                    if (m_valid) m_skid.push_back({rdata, m_addr + 32'd4});
                    else begin
                        m_instr = rdata;
                        m_pc4   = m_addr + 32'd4;
                        m_valid = 1'b1;
                    end
                    m_addr = m_addr + 32'd4;
                end
            end
        end
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        pcsrc;
        logic [31:0] npc;
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    function automatic vec_t mk(input logic pcsrc, input logic [31:0] npc, input logic stall,
                                input logic ack, input logic [31:0] rdata, input logic e_req,
                                input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_instr, input logic [31:0] e_pc4);
        vec_t v;
        v.pcsrc = pcsrc; v.npc = npc; v.stall = stall; v.ack = ack; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_pc4 = e_pc4;
        return v;
    endfunction

    localparam logic [31:0] A1 = 32'h1111_0000, A2 = 32'h1111_0004, A3 = 32'h1111_0008;
    localparam logic [31:0] J  = 32'h2008_0001, B1 = 32'h2222_0000, C1 = 32'h3333_0000;
    localparam logic [31:0] D1 = 32'h4444_0000, D2 = 32'h4444_0004, E1 = 32'h5555_0000;
    localparam logic [31:0] F1 = 32'h6666_0000, F2 = 32'h6666_0004, BAD = 32'hBAD0_BAD0;

    vec_t vecs[24];

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0,    1, 32'h0,   0, 0,  0);
        vecs[1]  = mk(0, 0, 0, 1, A1,   1, 32'h4,   1, A1, 32'h4);
        vecs[2]  = mk(0, 0, 0, 1, A2,   1, 32'h8,   1, A2, 32'h8);
        vecs[3]  = mk(0, 0, 0, 1, A3,   1, 32'hC,   1, A3, 32'hC);
        vecs[4]  = mk(0, 0, 1, 1, J,    0, 32'h10,  1, A3, 32'hC);
        vecs[5]  = mk(0, 0, 1, 0, 0,    0, 32'h10,  1, A3, 32'hC);
        vecs[6]  = mk(0, 0, 1, 1, BAD,  0, 32'h10,  1, A3, 32'hC);
        vecs[7]  = mk(0, 0, 0, 0, 0,    1, 32'h10,  1, J,  32'h10);
        vecs[8]  = mk(1, 32'h100, 0, 0, 0,   1, 32'h10,  0, J, 32'h10);
        vecs[9]  = mk(0, 0, 0, 0, 0,    1, 32'h10,  0, J,  32'h10);
        vecs[10] = mk(0, 0, 0, 1, BAD,  1, 32'h100, 0, J,  32'h10);
        vecs[11] = mk(0, 0, 0, 1, B1,   1, 32'h104, 1, B1, 32'h104);
        vecs[12] = mk(1, 32'h200, 0, 1, BAD, 1, 32'h200, 0, B1, 32'h104);
        vecs[13] = mk(0, 0, 0, 1, C1,   1, 32'h204, 1, C1, 32'h204);
        vecs[14] = mk(1, 32'h300, 0, 0, 0,   1, 32'h204, 0, C1, 32'h204);
        vecs[15] = mk(1, 32'h400, 0, 0, 0,   1, 32'h204, 0, C1, 32'h204);
        vecs[16] = mk(0, 0, 0, 1, BAD,  1, 32'h400, 0, C1, 32'h204);
        vecs[17] = mk(0, 0, 0, 1, D1,   1, 32'h404, 1, D1, 32'h404);
        vecs[18] = mk(0, 0, 1, 1, D2,   0, 32'h408, 1, D1, 32'h404);
        vecs[19] = mk(1, 32'h500, 1, 0, 0,   1, 32'h500, 0, D1, 32'h404);
        vecs[20] = mk(0, 0, 0, 1, E1,   1, 32'h504, 1, E1, 32'h504);
        vecs[21] = mk(1, 32'hFFFF_FFFC, 0, 1, BAD, 1, 32'hFFFF_FFFC, 0, E1, 32'h504);
        vecs[22] = mk(0, 0, 0, 1, F1,   1, 32'h0,   1, F1, 32'h0);
        vecs[23] = mk(0, 0, 0, 1, F2,   1, 32'h4,   1, F2, 32'h4);

        // Reset state
        idle_inputs();
        Reset = 1'b0;
        #2;
        chk("rst.req",   32'(Mem_Req),   32'd0);
        chk("rst.addr",  Mem_Addr,       RST_PC);
        chk("rst.valid", 32'(IF_Valid),  32'd0);
        chk("rst.instr", IF_Instruction, 32'd0);
        chk("rst.pc4",   IF_PC4,         32'd0);
        chk("rst.err",   32'(Fetch_Err), 32'd0);
        cyc();
        cyc();
        Reset = 1'b1;
        chk("boot.req",  32'(Mem_Req),   32'd0);

        // Directed table
        for (int i = 0; i < 24; i++) begin
            ID_PCSrc  = vecs[i].pcsrc;
            ID_new_PC = vecs[i].npc;
            Stall     = vecs[i].stall;
            Mem_Ack   = vecs[i].ack;
            Mem_RData = vecs[i].rdata;
            cyc();
            chk($sformatf("vec%0d.req", i),   32'(Mem_Req),   32'(vecs[i].e_req));
            chk($sformatf("vec%0d.addr", i),  Mem_Addr,       vecs[i].e_addr);
            chk($sformatf("vec%0d.valid", i), 32'(IF_Valid),  32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.instr", i), IF_Instruction, vecs[i].e_instr);
            chk($sformatf("vec%0d.pc4", i),   IF_PC4,         vecs[i].e_pc4);
            chk($sformatf("vec%0d.err", i),   32'(Fetch_Err), 32'd0);
        end

        // Reset asserted mid-request: immediate, and late ack ignored
        idle_inputs();
        #3;
        Reset = 1'b0;
        #1;
        chk("midrst.req",   32'(Mem_Req),   32'd0);
        chk("midrst.addr",  Mem_Addr,       RST_PC);
        chk("midrst.valid", 32'(IF_Valid),  32'd0);
        chk("midrst.instr", IF_Instruction, 32'd0);
        chk("midrst.pc4",   IF_PC4,         32'd0);
        Mem_Ack   = 1'b1;
        Mem_RData = 32'h1234_5678;
        cyc();
        chk("inrst.addr",   Mem_Addr,       RST_PC);
        chk("inrst.valid",  32'(IF_Valid),  32'd0);
        Reset = 1'b1;
        cyc();
        chk("boot2.req",    32'(Mem_Req),   32'd1);
        chk("boot2.addr",   Mem_Addr,       RST_PC);
        chk("boot2.valid",  32'(IF_Valid),  32'd0);
        cyc();
        chk("first.instr",  IF_Instruction, 32'h1234_5678);
        chk("first.pc4",    IF_PC4,         RST_PC + 32'd4);
        chk("first.valid",  32'(IF_Valid),  32'd1);

`ifdef FETCH_TIMEOUT_EN
        // Timeout raises sticky error after TMO unanswered REQ cycles
        do_reset();
        cyc();
        for (int i = 0; i < 3; i++) cyc();
        chk("tmo.before", 32'(Fetch_Err), 32'd0);
        cyc();
        chk("tmo.hit",    32'(Fetch_Err), 32'd1);
        chk("tmo.req",    32'(Mem_Req),   32'd1);
        Mem_Ack = 1'b1;
        cyc();
        chk("tmo.sticky", 32'(Fetch_Err), 32'd1);
        Reset = 1'b0;
        #1;
        chk("tmo.clear",  32'(Fetch_Err), 32'd0);
`endif

        // Randomized traffic against the reference model
        do_reset();
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            int          thr;
            thr       = ((i / 400) % 2 == 0) ? 3 : 1;
            r         = $urandom();
            ID_PCSrc  = !m_boot && ($urandom_range(0, 15) == 0);
            ID_new_PC = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (r & 32'hFFFF_FFFC);
            Stall     = ($urandom_range(0, 2) == 0);
            Mem_Ack   = (int'($urandom_range(0, 3)) < thr);
            Mem_RData = $urandom();
            m_step(ID_PCSrc, ID_new_PC, Stall, Mem_Ack, Mem_RData);
            cyc();
            chk($sformatf("rnd%0d.req", i),   32'(Mem_Req),   32'(m_req()));
            chk($sformatf("rnd%0d.addr", i),  Mem_Addr,       m_addr);
            chk($sformatf("rnd%0d.valid", i), 32'(IF_Valid),  32'(m_valid));
            chk($sformatf("rnd%0d.instr", i), IF_Instruction, m_instr);
            chk($sformatf("rnd%0d.pc4", i),   IF_PC4,         m_pc4);
            chk($sformatf("rnd%0d.err", i),   32'(Fetch_Err), 32'(m_err));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the first fetch address after reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, SHALL be the request-timeout threshold (used only under FETCH_TIMEOUT_EN).
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 ID_PCSrc  input  1  SHALL be the redirect strobe from decode, sampled every cycle.
REQ-006 ID_new_PC  input  32  SHALL be the redirect target, valid when ID_PCSrc=1.
REQ-007 Stall  input  1  SHALL be the hazard hold; 1 = decode does not consume IF register this cycle.
REQ-008 Mem_Ack  input  1  SHALL be instruction-memory completion, meaningful only while Mem_Req=1.
REQ-009 Mem_RData  input  32  SHALL be the instruction word, valid with Mem_Ack.
REQ-010 Mem_Req  output  1  SHALL be the fetch request to instruction memory.
REQ-011 Mem_Addr  output  32  SHALL be the fetch address, stable while Mem_Req=1 and no Mem_Ack.
REQ-012 IF_Instruction  output  32  SHALL be the IF/ID instruction register.
REQ-013 IF_PC4  output  32  SHALL be the fetch address of IF_Instruction plus 4.
REQ-014 IF_Valid  output  1  SHALL flag IF_Instruction as a live instruction.
REQ-015 Fetch_Err  output  1  SHALL flag a request timeout (see Configuration).

Function
REQ-016 States SHALL be BOOT, REQ and HOLD; BOOT->REQ unconditionally one cycle after Reset deasserts.
REQ-017 Mem_Req SHALL be 1 exactly in REQ; once asserted it SHALL stay 1 until the cycle of Mem_Ack.
REQ-018 Consume SHALL occur on any cycle with IF_Valid=1 and Stall=0; IF register is "free" when IF_Valid=0 or consume occurs.
REQ-019 REQ, Mem_Ack=1, IF free, no redirect: IF_Instruction<=Mem_RData, IF_PC4<=Mem_Addr+4, IF_Valid<=1, Mem_Addr<=Mem_Addr+4, stay REQ (back-to-back fetch, 1 instruction per cycle with zero-wait memory).
REQ-020 REQ, Mem_Ack=1, IF not free, no redirect: Mem_RData and Mem_Addr+4 SHALL park in a one-entry skid buffer, Mem_Addr<=Mem_Addr+4, go HOLD.
REQ-021 REQ, Mem_Ack=0, consume: IF_Valid<=0.
REQ-022 HOLD: Mem_Req=0; on Stall=0 skid SHALL move into IF register (IF_Valid stays 1) and state SHALL return to REQ; otherwise hold all.
REQ-023 Redirect (ID_PCSrc=1) SHALL take priority over Stall and Mem_Ack and SHALL clear IF_Valid and the skid buffer.
REQ-024 Redirect in REQ with Mem_Ack=0: ID_new_PC SHALL be stored and a discard flag set; the next Mem_Ack's data SHALL be dropped, Mem_Addr<=stored target, discard cleared, stay REQ.
REQ-025 Redirect in REQ with Mem_Ack=1, or in HOLD: data/skid dropped, Mem_Addr<=ID_new_PC, next state REQ.
REQ-026 Redirect while discard flag set SHALL overwrite the stored target (latest wins).
REQ-027 Address arithmetic SHALL be 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0 without error.
REQ-028 No delay slot: the instruction in IF at redirect is flushed.

Reset
REQ-029 Reset=0 SHALL immediately force: state BOOT, Mem_Req=0, Mem_Addr=RESET_PC, IF_Instruction=0, IF_PC4=0, IF_Valid=0, skid empty, discard=0, Fetch_Err=0, timeout counter=0.
REQ-030 Reset mid-request SHALL abandon it; a Mem_Ack arriving during or after reset before the first new request SHALL be ignored.

Configuration
REQ-031 With FETCH_TIMEOUT_EN defined: a counter SHALL count consecutive REQ cycles without Mem_Ack, clear on Mem_Ack, and set Fetch_Err=1 (sticky until reset) when it reaches TIMEOUT_CYCLES; fetching continues.
REQ-032 Without FETCH_TIMEOUT_EN: no counter SHALL be built and Fetch_Err SHALL be constant 0.

Verification
REQ-033 Reset release, Mem_Ack=1 whenever Mem_Req, Stall=0 -> Mem_Addr 0,4,8; IF_PC4 4,8,12 on consecutive cycles; IF_Valid=1 from 2nd cycle after BOOT.
REQ-034 IF_Valid=1, Stall=1 for 3 cycles, Mem_Ack with Mem_RData=32'h20080001 -> HOLD, Mem_Req=0, IF_Instruction unchanged; Stall=0 -> IF_Instruction=32'h20080001 next edge, Mem_Req=1.
REQ-035 Mem_Ack delayed 2 cycles, ID_PCSrc pulse with ID_new_PC=32'h100 in first wait cycle -> returned word dropped, IF_Valid=0, next Mem_Addr=32'h100.
REQ-036 ID_PCSrc=1 with ID_new_PC=32'h200 in same cycle as Mem_Ack -> word dropped, Mem_Addr=32'h200 next cycle, Mem_Req stays 1.
REQ-037 Reset=0 asserted during outstanding request -> all outputs at reset values before next Clk edge; Mem_Addr=RESET_PC.
REQ-038 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, Mem_Ack held 0 -> Fetch_Err=1 after 4th REQ cycle, stays 1 after later Mem_Ack until Reset=0.
